// File: rtl/fp16_mult_sched.sv
// ============================================================================
//  Module   : fp16_mult_sched
//  Purpose  : Round-robin scheduler sharing one pipelined FP16 multiplier
//             among N_REQ requesters; results are routed back by an in-order
//             tag FIFO of requester IDs.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fp16_mult_sched #(
  parameter int N_REQ        = 4,
  parameter int IDW          = 2,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [16*N_REQ-1:0]             req_a,
  input  logic [16*N_REQ-1:0]             req_b,
  output logic [N_REQ-1:0]                req_ready,
  output logic [N_REQ-1:0]                rsp_valid,
  output logic [15:0]                     rsp_data,
  output logic [15:0]                     mult_a,
  output logic [15:0]                     mult_b,
  output logic                            mult_valid_in,
  input  logic [15:0]                     mult_result,
  input  logic                            mult_valid_out,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err_orphan
);

  localparam int c_ptr_w = $clog2(MAX_INFLIGHT);
  localparam logic [c_ptr_w:0] c_max = (c_ptr_w+1)'(MAX_INFLIGHT);

  logic [IDW-1:0]   r_rr_ptr;
  logic [c_ptr_w:0] r_wr_ptr;
  logic [c_ptr_w:0] r_rd_ptr;
  logic [c_ptr_w:0] r_inflight;
  logic [IDW-1:0]   r_tag_mem [MAX_INFLIGHT];
  logic [15:0]      r_mult_a;
  logic [15:0]      r_mult_b;
  logic             r_mult_valid_in;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [15:0]      r_rsp_data;
  logic             r_err_orphan;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_win_next;
  logic             w_can_issue;
  logic             w_issue;
  logic             w_empty;
  logic             w_pop;
  logic [IDW-1:0]   w_tag;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      logic [IDW:0] idx;
      idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N_REQ)) idx = idx - (IDW+1)'(N_REQ);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = idx[IDW-1:0];
      end
    end
  end

  assign w_can_issue = (r_inflight < c_max);
  assign w_issue     = w_can_issue & w_found;
  assign w_win_next  = (w_win == IDW'(N_REQ-1)) ? '0 : w_win + 1'b1;
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_pop       = mult_valid_out & ~w_empty;
  assign w_tag       = r_tag_mem[r_rd_ptr[c_ptr_w-1:0]];

  for (genvar i = 0; i < N_REQ; i++) begin : g_ready
    assign req_ready[i] = w_issue && (w_win == IDW'(i));
  end

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_issue) r_tag_mem[r_wr_ptr[c_ptr_w-1:0]] <= w_win;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_inflight      <= '0;
      r_mult_a        <= '0;
      r_mult_b        <= '0;
      r_mult_valid_in <= 1'b0;
      r_rsp_valid     <= '0;
      r_rsp_data      <= '0;
      r_err_orphan    <= 1'b0;
    end else begin
      r_mult_valid_in <= w_issue;
      if (w_issue) begin
        r_mult_a <= req_a[w_win*16 +: 16];
        r_mult_b <= req_b[w_win*16 +: 16];
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= w_win_next;
      end
      r_rsp_valid <= '0;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_rsp_valid <= N_REQ'(1) << w_tag;
        r_rsp_data  <= mult_result;
      end
      if (mult_valid_out && w_empty) r_err_orphan <= 1'b1;
      case ({w_issue, w_pop})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign mult_a        = r_mult_a;
  assign mult_b        = r_mult_b;
  assign mult_valid_in = r_mult_valid_in;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign inflight      = r_inflight;
  assign err_orphan    = r_err_orphan;

endmodule

`default_nettype wire

// File: tb/tb_fp16_mult_sched.sv
// ============================================================================
//  Module   : tb_fp16_mult_sched
//  Purpose  : Bench for fp16_mult_sched; two instances (8 and 2 in flight)
//             driven in lockstep, each checked against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp16_mult_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        inj;

  logic [7:0]  ready_w, rspv_w, infl_w;
  logic [31:0] rspd_w, ma_w, mb_w, mres_w;
  logic [1:0]  mvi_w, mvo_w, orph_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural FP16 multiply for normal operands, truncating.
  function automatic logic [15:0] fpmul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] m;
    int          e;
    logic [9:0]  f;
    m = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (m[21]) begin
      f = m[20:11];
      e = e + 1;
    end else begin
      f = m[19:10];
    end
    return {a[15] ^ b[15], 5'(e), f};
  endfunction

  function automatic logic [15:0] rand_fp();
    return {1'($urandom), 5'(10 + $urandom_range(10)), 10'($urandom)};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int MI = (k == 0) ? 8 : 2;
    logic [$clog2(MI):0] infl;
    logic [2:0]          pv = 3'b000;
    logic [15:0]         pr [3];

    fp16_mult_sched #(.N_REQ(4), .IDW(2), .MAX_INFLIGHT(MI)) u_dut (
      .clk           (clk),
      .rstn          (rstn),
      .req_valid     (req_valid),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_ready     (ready_w[4*k +: 4]),
      .rsp_valid     (rspv_w[4*k +: 4]),
      .rsp_data      (rspd_w[16*k +: 16]),
      .mult_a        (ma_w[16*k +: 16]),
      .mult_b        (mb_w[16*k +: 16]),
      .mult_valid_in (mvi_w[k]),
      .mult_result   (mres_w[16*k +: 16]),
      .mult_valid_out(mvo_w[k]),
      .inflight      (infl),
      .err_orphan    (orph_w[k])
    );

    // Fixed-latency (L=3) multiplier stand-in; never reset so it drains.
    always @(posedge clk) begin
      pv    <= {pv[1:0], mvi_w[k]};
      pr[0] <= fpmul(ma_w[16*k +: 16], mb_w[16*k +: 16]);
      pr[1] <= pr[0];
      pr[2] <= pr[1];
    end
    assign mvo_w[k]            = pv[2] | inj;
    assign mres_w[16*k +: 16]  = pr[2];
    assign infl_w[4*k +: 4]    = 4'(infl);
  end

  int          maxin [2];
  int          rr [2], qh [2], qn [2];
  int          qt [2][16];
  logic [15:0] qp [2][16];
  logic [3:0]  e_rv [2];
  logic [15:0] e_rd [2], e_ma [2], e_mb [2];
  logic        e_mvi [2], e_orph [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rr[k] = 0; qh[k] = 0; qn[k] = 0;
      e_rv[k] = '0; e_rd[k] = '0; e_ma[k] = '0; e_mb[k] = '0;
      e_mvi[k] = 1'b0; e_orph[k] = 1'b0;
    end
  endtask

  task automatic reset_check();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready[%0d]", k), 32'(ready_w[4*k +: 4]), 0);
      chk($sformatf("rst_rspv[%0d]", k),  32'(rspv_w[4*k +: 4]), 0);
      chk($sformatf("rst_rspd[%0d]", k),  32'(rspd_w[16*k +: 16]), 0);
      chk($sformatf("rst_ma[%0d]", k),    32'(ma_w[16*k +: 16]), 0);
      chk($sformatf("rst_mb[%0d]", k),    32'(mb_w[16*k +: 16]), 0);
      chk($sformatf("rst_mvi[%0d]", k),   32'(mvi_w[k]), 0);
      chk($sformatf("rst_infl[%0d]", k),  32'(infl_w[4*k +: 4]), 0);
      chk($sformatf("rst_orph[%0d]", k),  32'(orph_w[k]), 0);
    end
  endtask

  // Compare instance k against the model, then advance the model one edge.
  task automatic model_step(input int k);
    int g;
    g = -1;
    if (qn[k] < maxin[k]) begin
      for (int j = 0; j < 4; j++) begin
        int i;
        i = (rr[k] + j) % 4;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    chk($sformatf("ready[%0d]", k), 32'(ready_w[4*k +: 4]), (g >= 0) ? (32'(1) << g) : 32'(0));
    chk($sformatf("rspv[%0d]", k),  32'(rspv_w[4*k +: 4]),  32'(e_rv[k]));
    chk($sformatf("rspd[%0d]", k),  32'(rspd_w[16*k +: 16]), 32'(e_rd[k]));
    chk($sformatf("mvi[%0d]", k),   32'(mvi_w[k]),          32'(e_mvi[k]));
    chk($sformatf("ma[%0d]", k),    32'(ma_w[16*k +: 16]),  32'(e_ma[k]));
    chk($sformatf("mb[%0d]", k),    32'(mb_w[16*k +: 16]),  32'(e_mb[k]));
    chk($sformatf("infl[%0d]", k),  32'(infl_w[4*k +: 4]),  32'(qn[k]));
    chk($sformatf("orph[%0d]", k),  32'(orph_w[k]),         32'(e_orph[k]));
    if (mvo_w[k]) begin
      if (qn[k] > 0) begin
        e_rv[k] = 4'(1) << qt[k][qh[k]];
        e_rd[k] = qp[k][qh[k]];
        qh[k]   = (qh[k] + 1) % 16;
        qn[k]   = qn[k] - 1;
      end else begin
        e_rv[k]   = '0;
        e_orph[k] = 1'b1;
      end
    end else begin
      e_rv[k] = '0;
    end
    if (g >= 0) begin
      int tl;
      tl         = (qh[k] + qn[k]) % 16;
      qt[k][tl]  = g;
      qp[k][tl]  = fpmul(req_a[16*g +: 16], req_b[16*g +: 16]);
      qn[k]      = qn[k] + 1;
      e_mvi[k]   = 1'b1;
      e_ma[k]    = req_a[16*g +: 16];
      e_mb[k]    = req_b[16*g +: 16];
      rr[k]      = (g + 1) % 4;
    end else begin
      e_mvi[k] = 1'b0;
    end
  endtask

  task automatic step();
    #1;
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    #1;
    reset_check();
    model_reset();
    #1;
    rstn = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = rand_fp();
      req_b[16*i +: 16] = rand_fp();
    end
  endtask

  initial begin
    maxin[0] = 8;
    maxin[1] = 2;
    rstn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; inj = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    reset_check();
    rstn = 1'b1;
    @(negedge clk);

    // Orphan result: flagged, sticky until reset.
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (4) step();
    chk("orphan_sticky0", 32'(orph_w[0]), 1);
    chk("orphan_sticky1", 32'(orph_w[1]), 1);
    reset_pulse();
    step();
    chk("orphan_cleared", 32'(orph_w), 0);

    // Single request from requester 2: 2.0 * 3.0.
    req_valid = 4'b0100;
    req_a[32 +: 16] = 16'h4000;
    req_b[32 +: 16] = 16'h4200;
    #1;
    chk("single_ready", 32'(ready_w[3:0]), 32'h4);
    step();
    req_valid = '0;
    repeat (4) step();
    chk("single_rspv", 32'(rspv_w[3:0]), 32'h4);
    chk("single_rspd", 32'(rspd_w[15:0]), 32'h4600);
    repeat (4) step();

    // Fairness: all four hold valid, operands tag the requester.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = 16'h3C00;
    end
    req_b = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("fair_grant", 32'(ready_w[3:0]), 32'(1) << (c % 4));
      step();
    end
    req_valid = '0;
    repeat (10) step();

    // Throttle: requester 0 continuously valid.
    req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      rand_ops();
      #1;
      chk("thr_infl_le2", 32'(infl_w[7:4] <= 4'd2), 1);
      step();
    end
    req_valid = '0;
    repeat (10) step();

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      req_valid = 4'($urandom);
      rand_ops();
      step();
    end
    req_valid = '0;
    repeat (12) step();

    // Reset with operations still in the multiplier.
    req_valid = 4'b0111;
    rand_ops();
    repeat (3) step();
    req_valid = '0;
    step();
    chk("mid_infl", 32'(infl_w[3:0]), 3);
    reset_pulse();
    repeat (6) step();
    chk("mid_orph0", 32'(orph_w[0]), 1);
    chk("mid_orph1", 32'(orph_w[1]), 1);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp16_mult_sched.md
Name: fp16_mult_sched

Overview:
- Shares one pipelined FP16 multiplier wrapper among N_REQ requesters using round-robin arbitration.
- Issues at most one multiply per cycle and records the requester ID of every issued operation in an in-order tag FIFO.
- Routes each result back to its originating requester.
- Sits between the SSM-update compute lanes and the single multiplier instance, so that lanes time-multiplex one DSP-based multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; equals clog2(N_REQ).
- MAX_INFLIGHT, 8, maximum number of issued operations without a returned result; also the tag FIFO depth (power of 2).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester operation valid
- req_a  in  16*N_REQ  packed FP16 operand A; requester i occupies bits [16i+15:16i]
- req_b  in  16*N_REQ  packed FP16 operand B, same packing as req_a
- req_ready  out  N_REQ  per-requester accept (grant)
- rsp_valid  out  N_REQ  per-requester result strobe, one-hot or zero
- rsp_data  out  16  result, shared by all requesters and qualified by rsp_valid
- mult_a  out  16  multiplier operand A
- mult_b  out  16  multiplier operand B
- mult_valid_in  out  1  multiplier input valid
- mult_result  in  16  multiplier result
- mult_valid_out  in  1  multiplier result valid
- inflight  out  clog2(MAX_INFLIGHT)+1  count of outstanding operations
- err_orphan  out  1  sticky error: a result arrived with the tag FIFO empty

Behaviour:
- Reset (rstn=0, asynchronous) clears:
  - rr_ptr to 0
  - tag FIFO pointers
  - inflight to 0
  - mult_a, mult_b, mult_valid_in to 0
  - rsp_valid to 0, rsp_data to 0
  - err_orphan to 0
- Grant logic (combinational):
  - can_issue = inflight < MAX_INFLIGHT.
  - The winner is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap.
  - req_ready is one-hot at the winner when can_issue; otherwise all zero.
  - req_ready never asserts for an index whose req_valid=0.
- Issue:
  - Handshake = req_valid[i] & req_ready[i].
  - On the next clk edge, register mult_a/mult_b from requester i and set mult_valid_in=1; otherwise mult_valid_in=0 (operands hold).
  - Push i into the tag FIFO.
  - Set rr_ptr = (i+1) mod N_REQ; rr_ptr is unchanged when there is no grant.
- The multiplier has no backpressure. The block assumes an in-order, fixed-latency L multiplier; the block itself does not depend on the value of L.
- Return:
  - When mult_valid_out=1 and the FIFO is non-empty, pop tag t.
  - Next cycle: rsp_valid[t]=1 and rsp_data=mult_result.
  - Otherwise rsp_valid=0 and rsp_data holds its previous value.
  - Requesters must sink rsp_valid unconditionally; there is no response backpressure.
- Orphan result: mult_valid_out=1 with the FIFO empty → the result is dropped, no rsp_valid is raised, and err_orphan is set to 1 until reset.
- inflight:
  - +1 on issue, −1 on pop, unchanged when both occur in the same cycle.
  - Always equals FIFO occupancy; never exceeds MAX_INFLIGHT.
- Issue and return in the same cycle, including the FIFO-full case: the pop frees a slot only for the following cycle. can_issue uses the registered inflight value, not the next-cycle value.
- End-to-end latency:
  - request handshake → mult_valid_in: 1 cycle
  - mult_valid_in → mult_valid_out: L cycles
  - mult_valid_out → rsp_valid: 1 cycle
  - total: L+2 cycles.
- Throughput: 1 operation per cycle when L+2 ≤ MAX_INFLIGHT. Otherwise issue throttles to MAX_INFLIGHT operations per L+2 cycles.
- Reset mid-operation:
  - All tags are discarded.
  - Results from the multiplier still draining after reset raise err_orphan. The multiplier is not flushed by this block.
- FIFO wrap-around: pointers carry one extra MSB for the full/empty distinction.

Test Plan:
- Single request: requester 2 sends a=0x4000 (2.0), b=0x4200 (3.0) → req_ready[2] in the same cycle, mult_valid_in one cycle later; with model L=3, rsp_valid=4'b0100 and rsp_data=0x4600 (6.0) 5 cycles after the handshake.
- Fairness: all 4 requesters hold req_valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; each response returns to the requester that issued it, verified by per-requester operand tagging (a=0x3C00, b=i+1 as FP16).
- Full throttle: MAX_INFLIGHT=2, L=3, continuous req_valid[0] → inflight saturates at 2, req_ready drops, at most 2 issues per 5 cycles, no lost or duplicated responses.
- Simultaneous issue and return at inflight=MAX_INFLIGHT → no grant that cycle, grant the next cycle, inflight stays ≤ MAX_INFLIGHT.
- Orphan: pulse mult_valid_out with no prior issue → no rsp_valid, err_orphan=1 and held until rstn=0.
- Reset mid-stream: deassert rstn with 3 operations in flight → all outputs 0 immediately; the 3 late results set err_orphan and produce no rsp_valid.
